// File: rtl/sampling_tile_scheduler.sv
// sampling_tile_scheduler: walks a frame in 8x8 tiles, feeds a 2x2 sampler and writes its averages to a half-size frame
`timescale 1ns/1ps
module sampling_tile_scheduler #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 16
) (
  input  logic          Clock,
  input  logic          Input_Reset_n,
  input  logic          Start,
  output logic          Busy,
  output logic          Done,
  output logic          Error,
  output logic [AW-1:0] Src_Addr,
  output logic          Src_Read,
  input  logic [15:0]   Src_Data,
  output logic [15:0]   Smp_Pixel,
  output logic          Smp_Valid,
  output logic          Smp_Reset,
  input  logic [15:0]   Smp_Out_Pixel,
  input  logic          Smp_Out_Valid,
  input  logic          Smp_Out_Finish,
  output logic [AW-1:0] Dst_Addr,
  output logic          Dst_Write,
  output logic [15:0]   Dst_Data
);
  localparam int TXN = IMG_W / 8;
  localparam int TYN = IMG_H / 8;
  localparam int TXW = TXN > 1 ? $clog2(TXN) : 1;
  localparam int TYW = TYN > 1 ? $clog2(TYN) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [TXW-1:0] tx_q, tx_d;
  logic [TYW-1:0] ty_q, ty_d;
  logic [6:0] rd_cnt_q, rd_cnt_d;
  logic [5:0] vld_cnt_q, vld_cnt_d;
  logic [4:0] k_q, k_d;
  logic rd_d1_q, rd_d1_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [AW-1:0] src_addr_q, src_addr_d, dst_addr_q, dst_addr_d;
  logic src_read_q, src_read_d, smp_valid_q, smp_valid_d, smp_reset_q, smp_reset_d;
  logic dst_write_q, dst_write_d;
  logic [15:0] smp_pixel_q, smp_pixel_d, dst_data_q, dst_data_d;
  logic last_x;
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    rd_cnt_d    = rd_cnt_q;
    vld_cnt_d   = vld_cnt_q;
    k_d         = k_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    src_addr_d  = src_addr_q;
    src_read_d  = 1'b0;
    smp_reset_d = 1'b0;
    dst_addr_d  = dst_addr_q;
    dst_write_d = 1'b0;
    dst_data_d  = dst_data_q;
    rd_d1_d     = src_read_q;
    smp_valid_d = rd_d1_q;
    smp_pixel_d = rd_d1_q ? Src_Data : smp_pixel_q;
    last_x      = tx_q == TXW'(TXN - 1);
    case (state_q)
      IDLE: if (Start) begin
        state_d     = CLEAR;
        tx_d        = '0;
        ty_d        = '0;
        error_d     = 1'b0;
        busy_d      = 1'b1;
        smp_reset_d = 1'b1;
        rd_cnt_d    = '0;
        vld_cnt_d   = '0;
        k_d         = '0;
      end
      CLEAR: state_d = FEED;
      FEED: if (smp_valid_q) begin
        vld_cnt_d = vld_cnt_q + 6'd1;
        state_d   = vld_cnt_q == 6'd63 ? DRAIN : FEED;
      end
      DRAIN: begin
        if (Smp_Out_Valid) begin
          if (k_q[4]) error_d = 1'b1;
          else begin
            dst_write_d = 1'b1;
            dst_data_d  = Smp_Out_Pixel;
            dst_addr_d  = (AW'(ty_q) * AW'(4) + AW'(k_q[3:2])) * AW'(IMG_W / 2) + AW'(tx_q) * AW'(4) + AW'(k_q[1:0]);
            k_d         = k_q + 5'd1;
          end
        end
        if (Smp_Out_Finish) begin
          state_d = NEXT;
          if (k_d != 5'd16) error_d = 1'b1;
        end
      end
      NEXT: begin
        tx_d        = last_x ? '0 : tx_q + TXW'(1);
        ty_d        = last_x ? ty_q + TYW'(1) : ty_q;
        state_d     = (last_x && ty_q == TYW'(TYN - 1)) ? DONE : CLEAR;
        done_d      = state_d == DONE;
        smp_reset_d = state_d == CLEAR;
        rd_cnt_d    = '0;
        vld_cnt_d   = '0;
        k_d         = '0;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == CLEAR || state_q == FEED) && !rd_cnt_q[6]) begin
      src_read_d = 1'b1;
      src_addr_d = (AW'(ty_q) * AW'(8) + AW'(rd_cnt_q[5:3])) * AW'(IMG_W) + AW'(tx_q) * AW'(8) + AW'(rd_cnt_q[2:0]);
      rd_cnt_d   = rd_cnt_q + 7'd1;
    end
    if (Smp_Out_Valid && state_q != DRAIN) error_d = 1'b1;
  end
  always_ff @(posedge Clock or negedge Input_Reset_n) begin
    if (!Input_Reset_n) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      ty_q        <= '0;
      rd_cnt_q    <= '0;
      vld_cnt_q   <= '0;
      k_q         <= '0;
      rd_d1_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      src_addr_q  <= '0;
      src_read_q  <= 1'b0;
      smp_pixel_q <= '0;
      smp_valid_q <= 1'b0;
      smp_reset_q <= 1'b0;
      dst_addr_q  <= '0;
      dst_write_q <= 1'b0;
      dst_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      rd_cnt_q    <= rd_cnt_d;
      vld_cnt_q   <= vld_cnt_d;
      k_q         <= k_d;
      rd_d1_q     <= rd_d1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      src_addr_q  <= src_addr_d;
      src_read_q  <= src_read_d;
      smp_pixel_q <= smp_pixel_d;
      smp_valid_q <= smp_valid_d;
      smp_reset_q <= smp_reset_d;
      dst_addr_q  <= dst_addr_d;
      dst_write_q <= dst_write_d;
      dst_data_q  <= dst_data_d;
    end
  end
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign Src_Addr  = src_addr_q;
  assign Src_Read  = src_read_q;
  assign Smp_Pixel = smp_pixel_q;
  assign Smp_Valid = smp_valid_q;
  assign Smp_Reset = smp_reset_q;
  assign Dst_Addr  = dst_addr_q;
  assign Dst_Write = dst_write_q;
  assign Dst_Data  = dst_data_q;
endmodule

// File: tb/tb_sampling_tile_scheduler.sv
// tb_sampling_tile_scheduler: directed bench with a source memory, a 2x2 sampler model and a destination scoreboard
`timescale 1ns/1ps
module tb_sampling_tile_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic busy, done, error, src_read, smp_valid, smp_reset, dst_write;
  logic [15:0] src_addr, dst_addr, smp_pixel, dst_data;
  logic [15:0] src_data = '0;
  logic [15:0] m_pix = '0;
  logic m_ov = 1'b0, m_fin = 1'b0, spur = 1'b0;
  logic smp_out_valid;
  int checks = 0, errors = 0;
  int n_out = 16, run = 0;
  int s_in = 0, s_out = 0;
  logic [15:0] spix [0:63];
  int wr_cnt = 0, done_cnt = 0, clr_cnt = 0, rd_n = 0, bad_addr = 0;
  logic [15:0] dst [0:3][0:63];
  logic [15:0] rd_log [0:63];
  assign smp_out_valid = m_ov | spur;
  sampling_tile_scheduler #(.IMG_W(16), .IMG_H(16), .AW(16)) dut (
    .Clock(clk), .Input_Reset_n(rst_n), .Start(start), .Busy(busy), .Done(done), .Error(error),
    .Src_Addr(src_addr), .Src_Read(src_read), .Src_Data(src_data),
    .Smp_Pixel(smp_pixel), .Smp_Valid(smp_valid), .Smp_Reset(smp_reset),
    .Smp_Out_Pixel(m_pix), .Smp_Out_Valid(smp_out_valid), .Smp_Out_Finish(m_fin),
    .Dst_Addr(dst_addr), .Dst_Write(dst_write), .Dst_Data(dst_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (src_read) src_data <= src_addr;
  function automatic logic [15:0] avg4(input int k);
    int b = (k / 4) * 16 + (k % 4) * 2;
    int s = int'(spix[b]) + int'(spix[b + 1]) + int'(spix[b + 8]) + int'(spix[b + 9]);
    return 16'(s / 4);
  endfunction
  always @(posedge clk) begin
    m_ov <= 1'b0;
    if (smp_reset) begin
      s_in  <= 0;
      s_out <= 0;
      m_fin <= 1'b0;
    end else if (smp_valid && s_in < 64) begin
      spix[s_in] <= smp_pixel;
      s_in <= s_in + 1;
    end else if (s_in == 64 && s_out < n_out) begin
      m_ov  <= 1'b1;
      m_pix <= avg4(s_out);
      s_out <= s_out + 1;
    end else if (s_in == 64) m_fin <= 1'b1;
  end
  always @(posedge clk) begin
    if (dst_write) begin
      wr_cnt <= wr_cnt + 1;
      if (dst_addr < 16'd64) dst[run][dst_addr[5:0]] <= dst_data;
      else bad_addr <= bad_addr + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (smp_reset) clr_cnt <= clr_cnt + 1;
    if (src_read && run == 0 && rd_n < 64) begin
      rd_log[rd_n] <= src_addr;
      rd_n <= rd_n + 1;
    end
  end
  function automatic logic [15:0] exp_dst(input int i);
    int a = 2 * (i / 8) * 16 + 2 * (i % 8);
    return 16'((a + (a + 1) + (a + 16) + (a + 17)) / 4);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      step(1);
      n++;
    end
    check("done_seen", 32'(done), 1);
    check("busy_at_done", 32'(busy), 1);
    step(1);
    check("done_drop", 32'(done), 0);
    check("busy_drop", 32'(busy), 0);
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_src_read"}, 32'(src_read), 0);
    check({tag, "_src_addr"}, 32'(src_addr), 0);
    check({tag, "_smp_valid"}, 32'(smp_valid), 0);
    check({tag, "_smp_pixel"}, 32'(smp_pixel), 0);
    check({tag, "_smp_reset"}, 32'(smp_reset), 0);
    check({tag, "_dst_write"}, 32'(dst_write), 0);
    check({tag, "_dst_addr"}, 32'(dst_addr), 0);
    check({tag, "_dst_data"}, 32'(dst_data), 0);
  endtask
  initial begin
    int n, bad, wtr, wb, db, cb;
    logic pv;
    #2 rst_n = 1'b0;
    step(2);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step(2);
    cb = clr_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    check("t1_smp_reset", 32'(smp_reset), 1);
    check("t1_src_read", 32'(src_read), 0);
    step(1);
    check("t2_smp_reset", 32'(smp_reset), 0);
    check("t2_src_read", 32'(src_read), 1);
    check("t2_src_addr", 32'(src_addr), 0);
    step(1);
    check("t3_src_addr", 32'(src_addr), 1);
    check("t3_smp_valid", 32'(smp_valid), 0);
    step(1);
    check("t4_smp_valid", 32'(smp_valid), 1);
    check("t4_smp_pixel", 32'(smp_pixel), 0);
    step(1);
    check("t5_smp_pixel", 32'(smp_pixel), 1);
    step(60);
    check("t65_src_read", 32'(src_read), 1);
    check("t65_src_addr", 32'(src_addr), 119);
    step(1);
    check("t66_src_read", 32'(src_read), 0);
    step(1);
    check("t67_smp_valid", 32'(smp_valid), 1);
    check("t67_smp_pixel", 32'(smp_pixel), 119);
    step(1);
    check("t68_smp_valid", 32'(smp_valid), 0);
    bad = 0;
    wtr = 0;
    pv = smp_out_valid;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (dst_write !== pv) bad++;
      if (dst_write === 1'b1) wtr++;
      pv = smp_out_valid;
    end
    check("dst_write_trails_valid", bad, 0);
    check("tile0_write_count", wtr, 16);
    wait_done();
    check("run0_writes", wr_cnt, 64);
    check("run0_done_count", done_cnt, 1);
    check("run0_clear_pulses", clr_cnt - cb, 4);
    check("run0_error", 32'(error), 0);
    check("run0_bad_addr", bad_addr, 0);
    check("dst0_0", 32'(dst[0][0]), 8);
    check("dst0_4", 32'(dst[0][4]), 16);
    check("dst0_32", 32'(dst[0][32]), 136);
    for (int i = 0; i < 64; i++) check($sformatf("run0_dst_%0d", i), 32'(dst[0][i]), 32'(exp_dst(i)));
    for (int i = 0; i < 64; i++) check($sformatf("tile0_src_addr_%0d", i), 32'(rd_log[i]), (i / 8) * 16 + i % 8);
    run = 1;
    pulse_start();
    n = 0;
    while (!(src_read === 1'b1 && src_addr === 16'd8) && n < 2000) begin
      step(1);
      n++;
    end
    check("tile1_feed_reached", 32'(src_addr), 8);
    step(3);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    step(2);
    check_idle_outputs("midreset_hold");
    rst_n = 1'b1;
    step(2);
    run = 2;
    wb = wr_cnt;
    db = done_cnt;
    pulse_start();
    step(100);
    check("busy_before_restart", 32'(busy), 1);
    pulse_start();
    wait_done();
    step(20);
    check("run2_writes", wr_cnt - wb, 64);
    check("run2_done_count", done_cnt - db, 1);
    check("run2_error", 32'(error), 0);
    for (int i = 0; i < 64; i++) check($sformatf("run2_dst_%0d", i), 32'(dst[2][i]), 32'(exp_dst(i)));
    run = 3;
    n_out = 15;
    wb = wr_cnt;
    db = done_cnt;
    pulse_start();
    wait_done();
    check("short_error", 32'(error), 1);
    check("short_writes", wr_cnt - wb, 60);
    check("short_done_count", done_cnt - db, 1);
    n_out = 16;
    wb = wr_cnt;
    pulse_start();
    check("start_clears_error", 32'(error), 0);
    n = 0;
    while (smp_valid !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check("feed_reached", 32'(smp_valid), 1);
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    check("spurious_error", 32'(error), 1);
    check("spurious_no_write", 32'(dst_write), 0);
    wait_done();
    check("spurious_writes", wr_cnt - wb, 64);
    check("spurious_error_sticky", 32'(error), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
